dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between a CPU core
// (zero-latency load/store) and a host burst engine.
//
//   state | meaning
//   IDLE  | core owns memory; host request sampled, starvation counted
//   BURST | host owns memory, one beat per cycle, core stalled
//   DONE  | one-cycle completion pulse; core guaranteed an uncontended slot
module dmem_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [3:0]    host_len,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_gnt,
  output logic          host_ack,
  output logic          host_done,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  localparam logic [3:0] STARVE_TH = 4'(STARVE);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    beats_q, beats_d;
  logic [3:0]    starve_q, starve_d;
  logic          gnt_q;

  // State and burst context registers; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      beats_q  <= '0;
      starve_q <= '0;
      gnt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      beats_q  <= beats_d;
      starve_q <= starve_d;
      gnt_q    <= (state_d == BURST);
    end
  end

  assign host_gnt = gnt_q;

  // Next-state logic and memory port steering.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    beats_d    = beats_q;
    starve_d   = '0;
    mem_addr   = core_addr;
    mem_dat_in = core_wdata;
    // Write enable is gated by reset so nothing lands in memory while held.
    mem_wr_en  = core_req & core_we & ~reset;
    core_rdata = mem_dat_out;
    core_stall = 1'b0;
    host_rdata = '0;
    host_ack   = 1'b0;
    host_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_req && host_req) begin
          starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
        end
        // The core is still served in the cycle that launches the burst.
        if (host_req && (!core_req || starve_q >= STARVE_TH)) begin
          state_d  = BURST;
          addr_d   = host_addr;
          we_d     = host_we;
          beats_d  = host_len;
          starve_d = '0;
        end
      end
      BURST: begin
        mem_addr   = addr_q;
        mem_dat_in = host_wdata;
        mem_wr_en  = we_q & ~reset;
        host_rdata = mem_dat_out;
        host_ack   = 1'b1;
        core_stall = core_req;
        addr_d     = addr_q + 1'b1;
        beats_d    = beats_q - 4'd1;
        if (beats_q == 4'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // host_req deliberately ignored here so the core always gets a slot.
        host_done = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
